// File: rtl/sigmoid_bwd_pipe.sv
// Sigmoid backward pass: dx = g * y * (1 - y) in Q3.12, three-stage
// valid/ready pipeline (clamp+product, scale, round).
module sigmoid_bwd_pipe #(
    parameter int W    = 16,
    parameter int FRAC = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] y,
    input  logic [W-1:0] g,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dx
);

    // Handshake: a beat moves on a rising edge where valid && ready on that
    // side; ready/valid outputs never look at in_valid, in_ready may look at
    // out_ready through the advance chain.

    localparam int ONE  = 1 << FRAC;
    localparam int HALF = 1 << (FRAC - 1);
    localparam int YW   = FRAC + 1;      // 0..ONE
    localparam int PW   = 2 * FRAC;      // yc * (ONE - yc) <= ONE^2 / 4
    localparam int DW   = FRAC - 1;      // d in 0..ONE/4
    localparam int MW   = W + DW;        // signed g * unsigned d

    logic          v1;
    logic          v2;
    logic          v3;
    logic [DW-1:0] d1;
    logic [W-1:0]  g1;
    logic [MW-1:0] m2;
    logic [W-1:0]  dx3;

    logic adv1;
    logic adv2;
    logic adv3;

    always_comb begin
        adv3 = !v3 || out_ready;
        adv2 = !v2 || adv3;
        adv1 = !v1 || adv2;
    end

    assign in_ready  = adv1;
    assign out_valid = v3;
    assign dx        = dx3;

    // S1: clamp y, form y*(1-y), round back to Q.12
    logic [YW-1:0] yc_n;
    logic [YW-1:0] s_n;
    logic [PW-1:0] p_n;
    logic [PW:0]   p_rnd;
    logic [DW-1:0] d_n;

    always_comb begin
        yc_n  = (y > W'(ONE)) ? YW'(ONE) : YW'(y);
        s_n   = YW'(ONE) - yc_n;
        p_n   = PW'(yc_n) * PW'(s_n);
        p_rnd = {1'b0, p_n} + (PW + 1)'(HALF);
        d_n   = DW'(p_rnd >> FRAC);
    end

    // S2: signed gradient times unsigned derivative
    logic signed [MW-1:0] g_ext;
    logic signed [MW-1:0] d_ext;
    logic signed [MW-1:0] m_n;

    always_comb begin
        g_ext = MW'($signed(g1));
        d_ext = MW'(d1);
        m_n   = g_ext * d_ext;
    end

    // S3: round half up; |dx| <= 2*ONE so the W-bit result never overflows
    logic signed [MW-1:0] r_n;
    logic [W-1:0]         dx_n;

    always_comb begin
        r_n  = $signed(m2) + MW'(HALF);
        dx_n = W'(r_n >>> FRAC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
            g1 <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                d1 <= d_n;
                g1 <= g;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
            m2 <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                m2 <= m_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3  <= 1'b0;
            dx3 <= '0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                dx3 <= dx_n;
            end
        end
    end

endmodule

// File: tb/tb_sigmoid_bwd_pipe.sv
// Self-checking bench for sigmoid_bwd_pipe: directed Q3.12 cases plus
// randomized streams against an arithmetic reference model.
module tb_sigmoid_bwd_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y;
    logic [15:0] g;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dx;

    int tests_run = 0;
    int fails = 0;

    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    sigmoid_bwd_pipe #(.W(16), .FRAC(12)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .y(y),
        .g(g),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dx(dx)
    );

    // dx = round_half_up(g * d / 4096), d = round(yc * (1 - yc)), floor division
    function automatic longint model_full(input int yv, input int gv);
        longint yc;
        longint d;
        longint r;
        longint q;
        yc = (yv > 4096) ? 4096 : yv;
        d  = (yc * (4096 - yc) + 2048) / 4096;
        r  = longint'(gv) * d + 2048;
        q  = r / 4096;
        if (r < 0 && (r % 4096) != 0) q = q - 1;
        return q;
    endfunction

    // Drive one cycle at the falling edge; report what the DUT shows for it.
    task automatic step(input logic iv, input logic [15:0] yy, input logic [15:0] gg,
                        input logic ordy, output logic acc, output logic ov,
                        output logic [15:0] od);
        @(negedge clk);
        in_valid  = iv;
        y         = yy;
        g         = gg;
        out_ready = ordy;
        #1;
        acc = iv && in_ready;
        ov  = out_valid;
        od  = dx;
        if (acc) exp_q.push_back(16'(model_full(int'(yy), int'($signed(gg)))));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        y = '0;
        g = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready_during got=%b want=1", in_ready);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        tests_run++;
        if (dx !== 16'd0) begin
            fails++; $display("FAIL reset_dx got=%0d want=0", dx);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_after got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_latency();
        logic acc, ov;
        logic [15:0] od, got, e;
        int lat = -1;
        step(1'b1, 16'd2048, 16'd4096, 1'b1, acc, ov, od);
        tests_run++;
        if (acc !== 1'b1) begin
            fails++; $display("FAIL latency_accept got=%b want=1", acc);
        end
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 16'd0, 16'd0, 1'b1, acc, ov, od);
            if (ov && lat < 0) begin
                lat = k;
                got = od;
            end
        end
        tests_run++;
        if (lat != 3) begin
            fails++; $display("FAIL latency_cycles got=%0d want=3", lat);
        end
        if (lat > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (got !== 16'd1024) begin
                fails++; $display("FAIL latency_dx got=%0d want=1024", got);
            end
            tests_run++;
            if (got !== e) begin
                fails++; $display("FAIL latency_model got=%0d want=%0d", got, e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_edge_cases();
        logic [15:0] ty [8] = '{16'd0, 16'd4096, 16'd5000, 16'd1024, 16'd1024, 16'd2048, 16'd2048, 16'd2048};
        logic [15:0] tg [8] = '{16'd4096, 16'd4096, 16'd4096, 16'd4096, 16'hE000, 16'h8000, 16'd1, 16'd2};
        logic [15:0] te [8] = '{16'd0, 16'd0, 16'd0, 16'd768, 16'hFA00, 16'hE000, 16'd0, 16'd1};
        logic acc, ov;
        logic [15:0] od, e, yy, gg;
        int sent = 0;
        int idx = 0;
        int cyc = 0;
        while ((sent < 8 || idx < 8) && cyc < 100) begin
            yy = (sent < 8) ? ty[sent] : 16'd0;
            gg = (sent < 8) ? tg[sent] : 16'd0;
            step(sent < 8, yy, gg, 1'b1, acc, ov, od);
            if (acc) sent++;
            if (ov) begin
                tests_run++;
                if (od !== te[idx]) begin
                    fails++; $display("FAIL edge_case[%0d] y=%0d got=%0d want=%0d", idx, ty[idx], $signed(od), $signed(te[idx]));
                end
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                tests_run++;
                if (od !== e) begin
                    fails++; $display("FAIL edge_model[%0d] got=%0d want=%0d", idx, $signed(od), $signed(e));
                end
                idx++;
            end
            cyc++;
        end
        tests_run++;
        if (cyc >= 100) begin
            fails++; $display("FAIL edge_timeout got=%0d outputs want=8", idx);
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [15:0] texp [5] = '{16'd1024, 16'd2048, 16'd3072, 16'd4096, 16'd5120};
        logic acc, ov, ordy;
        logic [15:0] od, e, held;
        int sent = 0;
        int idx = 0;
        int c = 0;
        held = '0;
        while (idx < 5 && c < 60) begin
            ordy = (c >= 6);
            step(sent < 5, 16'd2048, 16'(4096 * (sent + 1)), ordy, acc, ov, od);
            if (acc) sent++;
            if (c < 6) begin
                tests_run++;
                if (acc !== (c < 3)) begin
                    fails++; $display("FAIL bp_in_ready cycle=%0d got=%b want=%b", c, acc, c < 3);
                end
            end
            if (c == 3) begin
                held = od;
                tests_run++;
                if (ov !== 1'b1) begin
                    fails++; $display("FAIL bp_full_out_valid got=%b want=1", ov);
                end
            end
            if (c > 3 && c < 6) begin
                tests_run++;
                if (od !== held || ov !== 1'b1) begin
                    fails++; $display("FAIL bp_dx_stable cycle=%0d got=%0d want=%0d", c, od, held);
                end
            end
            if (c == 6) begin
                tests_run++;
                if (acc !== 1'b1) begin
                    fails++; $display("FAIL bp_pass_through got=%b want=1", acc);
                end
            end
            if (ov && ordy) begin
                tests_run++;
                if (od !== texp[idx]) begin
                    fails++; $display("FAIL bp_order[%0d] got=%0d want=%0d", idx, od, texp[idx]);
                end
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                tests_run++;
                if (od !== e) begin
                    fails++; $display("FAIL bp_model[%0d] got=%0d want=%0d", idx, od, e);
                end
                idx++;
            end
            c++;
        end
        tests_run++;
        if (idx != 5) begin
            fails++; $display("FAIL bp_timeout got=%0d outputs want=5", idx);
        end
        exp_q.delete();
    endtask

    task automatic test_streaming();
        logic acc, ov;
        logic [15:0] od, e, yy, gg;
        longint full;
        int bad_range = 0;
        for (int c = 0; c < 24; c++) begin
            yy = 16'($urandom_range(0, 5000));
            gg = 16'($urandom);
            full = model_full(int'(yy), int'($signed(gg)));
            if (c < 20 && (full > 8192 || full < -8192)) bad_range++;
            step(c < 20, yy, gg, 1'b1, acc, ov, od);
            if (c < 20) begin
                tests_run++;
                if (acc !== 1'b1) begin
                    fails++; $display("FAIL stream_in_ready cycle=%0d got=%b want=1", c, acc);
                end
            end
            if (c >= 3 && c < 23) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                tests_run++;
                if (ov !== 1'b1 || od !== e) begin
                    fails++; $display("FAIL stream_out cycle=%0d got valid=%b dx=%0d want valid=1 dx=%0d", c, ov, $signed(od), $signed(e));
                end
            end else if (c == 23) begin
                tests_run++;
                if (ov !== 1'b0) begin
                    fails++; $display("FAIL stream_drain got=%b want=0", ov);
                end
            end
        end
        tests_run++;
        if (bad_range != 0) begin
            fails++; $display("FAIL stream_no_truncation got=%0d out-of-range want=0", bad_range);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic acc, ov, ordy, iv, stalled;
        logic [15:0] od, e, prev_dx, yy, gg;
        int sent = 0;
        int got_n = 0;
        int c = 0;
        stalled = 1'b0;
        prev_dx = '0;
        while (got_n < 60 && c < 1000) begin
            iv   = (sent < 60) && ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 1) == 1);
            yy   = 16'($urandom_range(0, 4200));
            gg   = 16'($urandom);
            step(iv, yy, gg, ordy, acc, ov, od);
            if (acc) sent++;
            if (stalled) begin
                tests_run++;
                if (ov !== 1'b1 || od !== prev_dx) begin
                    fails++; $display("FAIL b2b_stall_hold cycle=%0d got valid=%b dx=%0d want 1/%0d", c, ov, od, prev_dx);
                end
            end
            if (ov && ordy) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                tests_run++;
                if (od !== e) begin
                    fails++; $display("FAIL b2b_model[%0d] got=%0d want=%0d", got_n, $signed(od), $signed(e));
                end
                got_n++;
            end
            stalled = ov && !ordy;
            prev_dx = od;
            c++;
        end
        tests_run++;
        if (got_n != 60 || exp_q.size() != 0) begin
            fails++; $display("FAIL b2b_count got=%0d left=%0d want 60/0", got_n, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic acc, ov;
        logic [15:0] od;
        int seen = 0;
        int lat = -1;
        logic [15:0] got;
        step(1'b1, 16'd1024, 16'd4096, 1'b1, acc, ov, od);
        step(1'b1, 16'd2048, 16'd8192, 1'b1, acc, ov, od);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL rmid_in_ready_during got=%b want=1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || dx !== 16'd0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL rmid_after got valid=%b dx=%0d ready=%b want 0/0/1", out_valid, dx, in_ready);
        end
        exp_q.delete();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 16'd0, 16'd0, 1'b1, acc, ov, od);
            if (ov) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            fails++; $display("FAIL rmid_discard got=%0d outputs want=0", seen);
        end
        step(1'b1, 16'd2048, 16'd4096, 1'b1, acc, ov, od);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 16'd0, 16'd0, 1'b1, acc, ov, od);
            if (ov && lat < 0) begin
                lat = k;
                got = od;
            end
        end
        tests_run++;
        if (lat != 3 || got !== 16'd1024) begin
            fails++; $display("FAIL rmid_next_beat got lat=%0d dx=%0d want 3/1024", lat, got);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_edge_cases();
        test_backpressure();
        test_streaming();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
